// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch front end feeding the control unit.
// It keeps the PC and runs one outstanding instruction-memory read at a time.
// It presents the captured word, its PC and the decoded fields downstream.
// Optional build macro FETCH_ALIGN_CHECK_EN adds a fetch_fault output and a
// sticky FAULT state for misaligned next PCs. Without it, the low two bits of
// every computed next PC are cleared.
module fetch_stage #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]       NOP_INSTR = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              pcSrc,
  input  logic [31:0]       imm,
  output logic              instr_valid,
  output logic [31:0]       instr_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [6:0]        opcode_o,
  output logic [2:0]        f3_o,
  output logic              f7_5_o
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic              fetch_fault
`endif
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    VALID = 3'd3
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    FAULT = 3'd4
`endif
  } fetchState_e;

  fetchState_e       state;
  logic [ADDR_W-1:0] fetchPc;
  logic [ADDR_W-1:0] immAddr;
  logic [ADDR_W-1:0] targetPc;
  logic [ADDR_W-1:0] nextPc;

  // The branch offset is sign-extended or truncated to the PC width.
  // Both adds wrap naturally modulo 2^ADDR_W.
  assign immAddr  = ADDR_W'($signed(imm));
  assign targetPc = pcSrc ? (pc_o + immAddr) : (pc_o + ADDR_W'(4));

`ifdef FETCH_ALIGN_CHECK_EN
  logic misaligned;
  assign nextPc     = targetPc;
  assign misaligned = |targetPc[1:0];
`else
  assign nextPc     = targetPc & ~ADDR_W'(3);
`endif

  // The request address is the held fetch PC, so it stays stable throughout REQ.
  assign imem_addr = fetchPc;
  assign opcode_o  = instr_o[6:0];
  assign f3_o      = instr_o[14:12];
  assign f7_5_o    = instr_o[30];

  // Single fetch FSM. Every output is registered and updated with the state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      fetchPc     <= RESET_PC;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instr_o     <= NOP_INSTR;
      pc_o        <= RESET_PC;
`ifdef FETCH_ALIGN_CHECK_EN
      fetch_fault <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
        end
        REQ: begin
          if (imem_gnt) begin
            state    <= WAIT;
            imem_req <= 1'b0;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            instr_o     <= imem_rdata;
            pc_o        <= fetchPc;
            instr_valid <= 1'b1;
            state       <= VALID;
          end
        end
        VALID: begin
          if (!stall) begin
            fetchPc     <= nextPc;
            instr_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            if (misaligned) begin
              state       <= FAULT;
              fetch_fault <= 1'b1;
            end else begin
              state    <= REQ;
              imem_req <= 1'b1;
            end
`else
            state    <= REQ;
            imem_req <= 1'b1;
`endif
          end
        end
`ifdef FETCH_ALIGN_CHECK_EN
        FAULT: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          fetch_fault <= 1'b1;
        end
`endif
        default: begin
          state       <= IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed plus randomized bench for fetch_stage.
// A behavioural PC model predicts every request address and captured word.
// Build macro FETCH_ALIGN_CHECK_EN enables the misalignment fault checks.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        pcSrc;
  logic [31:0] imm;
  logic        instr_valid;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [6:0]  opcode_o;
  logic [2:0]  f3_o;
  logic        f7_5_o;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_fault;
`endif

  int          vectors = 0;
  int          miscompares = 0;
  int          edges = 0;
  logic [31:0] modelPc;

  fetch_stage #(
    .ADDR_W(32),
    .RESET_PC(32'h0000_0000),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .stall(stall),
    .pcSrc(pcSrc),
    .imm(imm),
    .instr_valid(instr_valid),
    .instr_o(instr_o),
    .pc_o(pc_o),
    .opcode_o(opcode_o),
    .f3_o(f3_o),
    .f7_5_o(f7_5_o)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .fetch_fault(fetch_fault)
`endif
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count rising edges so fetch latency can be measured in edges.
  always @(posedge clk) edges++;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic stallV, input logic pcSrcV,
                               input logic [31:0] immV);
    stall = stallV;
    pcSrc = pcSrcV;
    imm   = immV;
    tick();
  endtask

  // Reference next-PC rule, evaluated with plain 32-bit modular arithmetic.
  function automatic logic [31:0] modelNext(input logic [31:0] pc,
                                            input logic takeBranch,
                                            input logic [31:0] offset);
    logic [31:0] raw;
    raw = takeBranch ? pc + offset : pc + 32'd4;
`ifdef FETCH_ALIGN_CHECK_EN
    return raw;
`else
    return raw & 32'hFFFF_FFFC;
`endif
  endfunction

  task automatic waitReq();
    int budget = 50;
    while (imem_req !== 1'b1 && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) checkOutput("reqTimeout", 32'(imem_req), 32'd1);
  endtask

  task automatic serveFetch(input logic [31:0] word, input int gntDelay,
                            input int rvDelay, input bit spurious);
    logic [31:0] addrSeen;
    waitReq();
    checkOutput("reqAddr", imem_addr, modelPc);
    addrSeen = imem_addr;
    for (int i = 0; i < gntDelay; i++) begin
      imem_rvalid = spurious;
      imem_rdata  = 32'hBAD0_0000 | 32'(i);
      tick();
      checkOutput("reqHeld", 32'(imem_req), 32'd1);
      checkOutput("addrStable", imem_addr, addrSeen);
      checkOutput("noValidInReq", 32'(instr_valid), 32'd0);
    end
    imem_rvalid = 1'b0;
    imem_gnt    = 1'b1;
    tick();
    imem_gnt = 1'b0;
    checkOutput("reqDropAfterGnt", 32'(imem_req), 32'd0);
    for (int i = 0; i < rvDelay; i++) begin
      tick();
      checkOutput("noValidInWait", 32'(instr_valid), 32'd0);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    checkOutput("validAfterData", 32'(instr_valid), 32'd1);
    checkOutput("instrCaptured", instr_o, word);
    checkOutput("pcCaptured", pc_o, modelPc);
    checkOutput("opcodeField", 32'(opcode_o), word & 32'h7F);
    checkOutput("f3Field", 32'(f3_o), (word >> 12) & 32'h7);
    checkOutput("f7bitField", 32'(f7_5_o), (word >> 30) & 32'h1);
  endtask

  task automatic consume(input logic takeBranch, input logic [31:0] offset);
    modelPc = modelNext(modelPc, takeBranch, offset);
    applyStimulus(1'b0, takeBranch, offset);
    stall = 1'b1;
    pcSrc = 1'b0;
    imm   = $urandom;
    checkOutput("validDropAfterConsume", 32'(instr_valid), 32'd0);
    checkOutput("reqAfterConsume", 32'(imem_req), 32'd1);
    checkOutput("nextAddr", imem_addr, modelPc);
  endtask

  task automatic stallHold(input int cycles, input bit junkData);
    logic [31:0] heldInstr;
    logic [31:0] heldPc;
    heldInstr = instr_o;
    heldPc    = pc_o;
    for (int i = 0; i < cycles; i++) begin
      imem_rvalid = junkData;
      imem_rdata  = 32'hDEAD_0000 | 32'(i);
      applyStimulus(1'b1, 1'(i & 1), $urandom);
      checkOutput("stallInstrHeld", instr_o, heldInstr);
      checkOutput("stallPcHeld", pc_o, heldPc);
      checkOutput("stallNoReq", 32'(imem_req), 32'd0);
      checkOutput("stallValidHeld", 32'(instr_valid), 32'd1);
    end
    imem_rvalid = 1'b0;
    pcSrc       = 1'b0;
  endtask

  // Linear sequence of directed steps followed by a randomized run.
  initial begin
    int startEdge;
    logic [31:0] word;
    logic [31:0] immV;
    int off;

    rst_n       = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    stall       = 1'b1;
    pcSrc       = 1'b0;
    imm         = 32'h0;
    modelPc     = 32'h0;
    tick();
    tick();

    $display("[TB] reset values");
    checkOutput("rstReq", 32'(imem_req), 32'd0);
    checkOutput("rstAddr", imem_addr, 32'h0);
    checkOutput("rstValid", 32'(instr_valid), 32'd0);
    checkOutput("rstInstr", instr_o, 32'h0000_0013);
    checkOutput("rstPc", pc_o, 32'h0);
    checkOutput("rstOpcode", 32'(opcode_o), 32'h13);
`ifdef FETCH_ALIGN_CHECK_EN
    checkOutput("rstFault", 32'(fetch_fault), 32'd0);
`endif

    $display("[TB] first fetch at minimum latency");
    rst_n     = 1'b1;
    startEdge = edges;
    serveFetch(32'h0000_0003, 0, 0, 1'b0);
    checkOutput("firstLatencyEdges", 32'(edges - startEdge), 32'd3);

    $display("[TB] sequential fetches");
    consume(1'b0, 32'h0);
    serveFetch(32'h0000_0023, 0, 0, 1'b0);
    consume(1'b0, 32'h0);
    serveFetch(32'h0000_0033, 0, 0, 1'b0);
    checkOutput("seqPc8", pc_o, 32'h8);

    $display("[TB] branches backward and forward");
    consume(1'b1, 32'hFFFF_FFF8);
    checkOutput("backBranchAddr", imem_addr, 32'h0);
    serveFetch(32'h4000_7063, 0, 1, 1'b0);
    consume(1'b1, 32'h0000_0010);
    checkOutput("fwdBranchAddr", imem_addr, 32'h10);
    serveFetch(32'h0020_8133, 1, 0, 1'b0);

    $display("[TB] stall hold with pcSrc toggling");
    stallHold(5, 1'b1);
    consume(1'b0, 32'h0);
    checkOutput("afterStallAddr", imem_addr, 32'h14);

    $display("[TB] delayed grant and data with spurious rvalid");
    serveFetch(32'h4001_5093, 3, 4, 1'b1);

    $display("[TB] PC wraps past the top of the address space");
    consume(1'b1, 32'hFFFF_FFFC - modelPc);
    checkOutput("wrapTopAddr", imem_addr, 32'hFFFF_FFFC);
    serveFetch(32'h0000_0013, 0, 0, 1'b0);
    consume(1'b0, 32'h0);
    checkOutput("wrapZeroAddr", imem_addr, 32'h0);

    $display("[TB] reset during WAIT drops the pending response");
    waitReq();
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("midRstReq", 32'(imem_req), 32'd0);
    checkOutput("midRstValid", 32'(instr_valid), 32'd0);
    checkOutput("midRstInstr", instr_o, 32'h0000_0013);
    checkOutput("midRstAddr", imem_addr, 32'h0);
    tick();
    rst_n       = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hCAFE_F00D;
    tick();
    tick();
    imem_rvalid = 1'b0;
    checkOutput("staleInstrDropped", instr_o, 32'h0000_0013);
    checkOutput("staleValidLow", 32'(instr_valid), 32'd0);
    checkOutput("restartReq", 32'(imem_req), 32'd1);
    checkOutput("restartAddr", imem_addr, 32'h0);
    modelPc = 32'h0;
    serveFetch(32'h0000_0003, 0, 0, 1'b0);

    $display("[TB] randomized fetch stream");
    for (int n = 0; n < 40; n++) begin
      off  = int'($urandom_range(0, 63)) - 32;
      immV = 32'(off * 4);
`ifndef FETCH_ALIGN_CHECK_EN
      if ($urandom_range(0, 3) == 0) immV = immV | 32'($urandom_range(1, 3));
`endif
      stallHold(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      consume(1'($urandom_range(0, 1)), immV);
      word = $urandom;
      serveFetch(word, int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                 1'($urandom_range(0, 1)));
    end

`ifdef FETCH_ALIGN_CHECK_EN
    $display("[TB] misaligned branch raises a sticky fault");
    applyStimulus(1'b0, 1'b1, 32'h0000_0002);
    stall = 1'b1;
    pcSrc = 1'b0;
    checkOutput("faultRaised", 32'(fetch_fault), 32'd1);
    checkOutput("faultValidLow", 32'(instr_valid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      imem_gnt = 1'b1;
      tick();
      checkOutput("faultNoReq", 32'(imem_req), 32'd0);
      checkOutput("faultHeld", 32'(fetch_fault), 32'd1);
    end
    imem_gnt = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage that sits directly upstream of the control unit UC.
- Holds the PC and issues single-outstanding requests to instruction memory.
- Captures the returned word and presents it, with its PC and the decoded opcode/funct3/funct7[5] fields, to UC.
- Computes the next PC from UC's pcSrc decision and the branch offset when the instruction is consumed.

Parameters:
ADDR_W, 32, width of PC and memory address
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0013, instruction word presented while nothing valid (addi x0,x0,0)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  memory request valid
imem_addr  out  ADDR_W  request address
imem_gnt  in  1  memory accepted request this cycle
imem_rvalid  in  1  read data valid
imem_rdata  in  32  read data
stall  in  1  downstream not ready; holds current instruction
pcSrc  in  1  from UC: take branch target
imm  in  32  branch offset relative to pc_o, sign-extended
instr_valid  out  1  instr_o/pc_o/fields valid
instr_o  out  32  captured instruction
pc_o  out  ADDR_W  address of instr_o
opcode_o  out  7  instr_o[6:0]
f3_o  out  3  instr_o[14:12]
f7_5_o  out  1  instr_o[30]

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; fetch_pc=RESET_PC; imem_req=0; imem_addr=RESET_PC.
  - instr_valid=0; instr_o=NOP_INSTR; pc_o=RESET_PC.
  - Field outputs are always combinational slices of instr_o.
- FSM states: IDLE, REQ, WAIT, VALID.
- IDLE: always moves to REQ on the next edge.
- REQ:
  - imem_req=1; imem_addr=fetch_pc, held stable until imem_gnt.
  - On imem_gnt, go to WAIT.
  - imem_rvalid in REQ is ignored.
- WAIT:
  - imem_req=0. On imem_rvalid: instr_o<=imem_rdata, pc_o<=fetch_pc, go to VALID.
  - Memory latency is unbounded.
- VALID:
  - instr_valid=1.
  - Consume occurs at an edge with stall=0. pcSrc and imm are sampled at that same edge.
  - On consume: fetch_pc <= pcSrc ? pc_o+imm : pc_o+4, then go to REQ. instr_valid drops the following cycle.
  - With stall=1: instr_o, pc_o and fields are held unchanged; pcSrc and imm are ignored.
  - imem_rvalid in VALID or IDLE is ignored (stale response dropped).
- Arithmetic: PC adds are modulo 2^ADDR_W. imm is truncated to ADDR_W. 0xFFFF_FFFC+4 wraps to 0.
- Minimum latency (gnt in first REQ cycle, rvalid the following cycle):
  - rst_n release edge E0: IDLE.
  - E1: REQ. E2: WAIT. E3: VALID, instr_valid=1 after E3.
  - Back-to-back throughput is 1 instruction per 3 cycles.
- Reset mid-operation: any state returns immediately to IDLE with the reset values. A response pending from before reset is discarded.

Optional Feature:
FETCH_ALIGN_CHECK_EN
- Defined:
  - Adds output port fetch_fault (1 bit, reset 0) and a FAULT state.
  - If a computed next PC has [1:0]!=0 at consume, go to FAULT instead of REQ.
  - In FAULT: imem_req=0, instr_valid=0, fetch_fault=1; held until reset.
- Not defined: no port and no FAULT state; next-PC bits [1:0] are forced to 0.

Test Plan:
- Reset then gnt/rvalid immediate, rdata=0x00000003 -> imem_addr=0 at first request; instr_valid=1 three edges after reset release; opcode_o=3, pc_o=0.
- Consume with pcSrc=0, rdata sequence 0x00000023, 0x00000033 -> second request addr=4, pc_o=4, opcode_o=35 then 51.
- At pc_o=8, pcSrc=1, imm=0xFFFFFFF8 on consume -> next imem_addr=0. Then imm=0x10 from pc 0 -> addr=0x10.
- Hold stall=1 for 5 cycles in VALID with pcSrc toggling -> instr_o/pc_o unchanged, no imem_req. Release stall -> one request to pc_o+4.
- Delay gnt 3 cycles and rvalid 4 cycles; inject spurious rvalid in REQ -> imem_addr stable during REQ; spurious data not captured; correct word captured.
- Assert rst_n=0 during WAIT, then rvalid arrives after release while in IDLE/REQ -> dropped; instr_o=0x00000013, fetch restarts at RESET_PC. With FETCH_ALIGN_CHECK_EN: pcSrc=1, imm=2 -> fetch_fault=1, no further requests.
